// File: rtl/apb_gpio.sv
// APB-attached 8-bit GPIO: direction and output latch registers with SET/CLR
// write ports. Pins drive OUT only where DIR enables them.
module apb_gpio (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [2:0] PADDR,
  input  logic [7:0] PWDATA,
  input  logic       PWRITE,
  input  logic       PSEL,
  input  logic       PENABLE,
  output logic [7:0] PRDATA,
  output logic       pin1,
  output logic       pin2,
  output logic       pin3,
  output logic       pin4,
  output logic       pin5,
  output logic       pin6,
  output logic       pin7,
  output logic       pin8
);

  localparam logic [2:0] ADDR_DIR    = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic [7:0] dir_q, dir_d;
  logic [7:0] out_q, out_d;
  logic [7:0] pins;
  logic       wr_stb;

  assign wr_stb = PSEL & PENABLE & PWRITE;

  // Address 1 reads back the latch even though writes there act as SET.
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    if (wr_stb) begin
      case (PADDR)
        ADDR_DIR: dir_d = PWDATA;
        ADDR_SET: out_d = out_q | PWDATA;
        ADDR_CLR: out_d = out_q & ~PWDATA;
        default:  ;
      endcase
    end
  end

  // PRESETn is active-high despite its name.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      dir_q <= 8'h00;
      out_q <= 8'h00;
    end else begin
      dir_q <= dir_d;
      out_q <= out_d;
    end
  end

  assign pins = out_q & dir_q;

  always_comb begin
    PRDATA = 8'h00;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        ADDR_DIR:    PRDATA = dir_q;
        ADDR_SET:    PRDATA = out_q;
        ADDR_STATUS: PRDATA = pins;
        default:     PRDATA = 8'h00;
      endcase
    end
  end

  assign pin1 = pins[0];
  assign pin2 = pins[1];
  assign pin3 = pins[2];
  assign pin4 = pins[3];
  assign pin5 = pins[4];
  assign pin6 = pins[5];
  assign pin7 = pins[6];
  assign pin8 = pins[7];

endmodule

// File: tb/tb_apb_gpio.sv
// Directed bench for apb_gpio: hand-computed expectations checked with
// immediate assertions after each step.
module tb_apb_gpio;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic       PWRITE;
  logic       PSEL;
  logic       PENABLE;
  logic [7:0] PRDATA;
  logic       pin1, pin2, pin3, pin4, pin5, pin6, pin7, pin8;
  logic [7:0] pins;
  logic [7:0] rd;
  int         total = 0;
  int         bad   = 0;

  assign pins = {pin8, pin7, pin6, pin5, pin4, pin3, pin2, pin1};

  apb_gpio dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .pin1(pin1), .pin2(pin2), .pin3(pin3), .pin4(pin4),
    .pin5(pin5), .pin6(pin6), .pin7(pin7), .pin8(pin8)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 3'd0; PWDATA = 8'h00;
  endtask

  // Two-phase zero-wait write; inputs change 1 time unit after each edge.
  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    idle();
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 d = PRDATA;
    idle();
    #1;
  endtask

  initial begin
    idle();
    PRESETn = 1'b1;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b0;

    check("reset_pins", pins, 8'h00);
    apb_read(3'd0, rd); check("reset_dir", rd, 8'h00);
    apb_read(3'd1, rd); check("reset_out", rd, 8'h00);
    check("prdata_idle", PRDATA, 8'h00);

    apb_write(3'd0, 8'h01);
    apb_write(3'd1, 8'h01);
    apb_write(3'd2, 8'h00);
    check("pin1_only", pins, 8'h01);

    apb_write(3'd0, 8'h03);
    apb_write(3'd1, 8'h03);
    check("pins12", pins, 8'h03);
    apb_write(3'd2, 8'h02);
    check("clr_pin2", pins, 8'h01);

    apb_write(3'd0, 8'hFB);
    apb_read(3'd4, rd); check("status_fb", rd, 8'h01);
    apb_read(3'd0, rd); check("dir_fb", rd, 8'hFB);
    apb_read(3'd1, rd); check("out_01", rd, 8'h01);
    apb_read(3'd2, rd); check("rd_addr2", rd, 8'h00);
    apb_read(3'd7, rd); check("rd_addr7", rd, 8'h00);

    // Writes to unmapped addresses change nothing.
    apb_write(3'd5, 8'hFF);
    apb_write(3'd3, 8'hFF);
    apb_read(3'd0, rd); check("ign_dir", rd, 8'hFB);
    apb_read(3'd1, rd); check("ign_out", rd, 8'h01);

    apb_write(3'd0, 8'h08);
    apb_write(3'd1, 8'h08);
    check("pin4_only", pins, 8'h08);
    apb_read(3'd1, rd); check("out_09", rd, 8'h09);

    // DIR cleared hides latch; DIR set again restores pins.
    apb_write(3'd0, 8'h00);
    check("dir0_pins", pins, 8'h00);
    apb_write(3'd0, 8'h09);
    check("dir9_pins", pins, 8'h09);
    apb_write(3'd0, 8'h08);

    // Setup-only cycle and PSEL=0 access must not write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd1; PWDATA = 8'hFF;
    check("prdata_wr", PRDATA, 8'h00);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(posedge PCLK); #1;
    idle();
    apb_read(3'd1, rd); check("noacc_out", rd, 8'h09);
    check("noacc_pins", pins, 8'h08);

    // Reset during an access phase beats the SET=FF strobe.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd1; PWDATA = 8'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESETn = 1'b1;
    @(posedge PCLK); #1;
    idle(); PRESETn = 1'b0;
    check("rst_pins", pins, 8'h00);
    apb_read(3'd0, rd); check("rst_dir", rd, 8'h00);
    apb_read(3'd1, rd); check("rst_out", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
